fp_add_normalizer: RTL and testbench
====================================

Name: fp_add_normalizer

Overview:
- Consumer end of the 24-bit sign-magnitude mantissa adder/subtractor interface: takes raw `{c_out, sum}`, result sign, and the common aligned biased exponent.
- Normalizes the mantissa iteratively, one shift per cycle.
- Packs an IEEE-754 single-precision word and raises status flags.
- Sits directly downstream of the mantissa adder in the floating-point add/sub datapath, loaded when the adder reports ready.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, biased exponent width.
- EXP_MAX, 255, all-ones exponent (infinity encoding).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  clock enable; when low, all state holds.
- load  input  1  capture inputs and start normalization.
- sum  input  24  raw adder mantissa result.
- c_out  input  1  adder carry-out (mantissa bit 24).
- sign_in  input  1  result sign from the adder.
- exp_in  input  8  biased exponent of the aligned operands.
- result  output  32  packed `{sign, exp[7:0], frac[22:0]}`.
- ready  output  1  result valid; held until next load or reset.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  result is denormal (exponent field 0, nonzero frac).
- zero  output  1  result magnitude is zero.

Behaviour:
- Reset: rst_n low at a rising edge clears state to IDLE; result=0, ready=0, overflow=0, underflow=0, zero=0. Reset has priority over en and load, including mid-normalization.
- en low: FSM, registers and outputs frozen; load is ignored.
- FSM states: IDLE, NORM, DONE.
- Load: en=1 and load=1 at edge N, from any state (aborts an in-progress normalization):
  - Registers mant25=`{c_out,sum}`, exp=exp_in, sign=sign_in.
  - Clears ready and all flags.
  - Enters NORM.
- NORM, one step per enabled edge, priority order:
  1. mant25==0: zero=1, result=`{sign,31'b0}`, go DONE.
  2. mant25[24]==1:
     - If exp>=EXP_MAX-1: overflow=1, result=`{sign,8'hFF,23'b0}`, go DONE.
     - Else mant25 >>= 1 (LSB dropped, truncation), exp += 1, stay NORM.
  3. mant25[23]==1: result=`{sign,exp,mant25[22:0]}`, go DONE.
  4. exp<=1:
     - Denormal: exponent field 0, frac=mant25[22:0].
     - underflow=1, go DONE.
     - Input exp_in==0 takes this path with no shifts.
  5. Otherwise mant25 <<= 1, exp -= 1, stay NORM.
- DONE: ready=1; result and flags held. Returns to IDLE only on reset; a new load restarts from DONE directly.
- Latency: with load at edge N and k shift steps, ready=1 after edge N+1+k.
  - Already-normalized input: k=0.
  - Carry-out input: k=1.
  - Worst case: k=23 (sum=1).
- Flags are mutually exclusive. ready is never 1 in the same cycle as a stale result.

Optional Feature:
FP_NORM_ROUND_EN
- Defined: the right shift (carry case) applies round-half-to-even using the dropped bit as round bit, with no sticky (single dropped bit).
  - On a tie, increment if the kept LSB is 1.
  - If the increment carries into bit 24, do one more NORM right-shift step: k=2, and the overflow check applies again.
- Not defined: dropped bit is discarded (truncation). Results match the base behaviour exactly.
- Directed check, macro defined:
  - c_out=1, sum=0x800003, exp_in=0x80 gives result 0x40C00002.
  - c_out=1, sum=0x800001, exp_in=0x80 gives 0x40C00000.

Test Plan:
- Normalized input: sum=0x800000, c_out=0, sign_in=0, exp_in=0x80, load pulse -> ready after edge N+1, result=0x40000000, all flags 0.
- Carry renormalize: sum=0x800000, c_out=1, exp_in=0x80 -> ready after edge N+2, result=0x40C00000.
- Max left shift: sum=0x000001, sign_in=1, exp_in=0x90 -> ready after edge N+24, result=0xBC800000.
- Underflow: sum=0x000100, exp_in=0x03 -> two shifts, result=0x00000400, underflow=1.
- Overflow: sum=0x800000, c_out=1, exp_in=0xFE -> result=0x7F800000, overflow=1.
- Zero and abort: sum=0, sign_in=0 -> result=0, zero=1. Then load sum=1, exp_in=0x90, and drive rst_n low at edge N+5 -> ready=0, result=0, flags 0. Also hold en=0 mid-NORM for 3 cycles -> latency extends by exactly 3.

Source files
------------

// File: rtl/fp_add_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_normalizer
// Brief    : Iterative post-add normalizer; packs IEEE-754 single and flags.
//            Optional macro FP_NORM_ROUND_EN: round-half-to-even on carry shift.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_normalizer #(
    parameter int MANT_W  = 24,
    parameter int EXP_W   = 8,
    parameter int EXP_MAX = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic [MANT_W-1:0]        sum,
    input  logic                     c_out,
    input  logic                     sign_in,
    input  logic [EXP_W-1:0]         exp_in,
    output logic [EXP_W+MANT_W-1:0]  result,
    output logic                     ready,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [EXP_W-1:0] C_EXP_OVF = EXP_W'(EXP_MAX - 1);
    localparam logic [EXP_W-1:0] C_EXP_INF = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] C_EXP_ONE = EXP_W'(1);

    logic [1:0]              r_state, w_state;
    logic [MANT_W:0]         r_mant, w_mant;
    logic [EXP_W-1:0]        r_exp, w_exp;
    logic                    r_sign, w_sign;
    logic [EXP_W+MANT_W-1:0] r_result, w_result;
    logic                    r_ready, w_ready;
    logic                    r_ovf, w_ovf;
    logic                    r_unf, w_unf;
    logic                    r_zero, w_zero;
    logic [MANT_W:0]         w_shr;

    // A single dropped bit of 1 is always a tie, so round up only to reach even.
`ifdef FP_NORM_ROUND_EN
    assign w_shr = {1'b0, r_mant[MANT_W:1]} + (MANT_W+1)'(r_mant[0] & r_mant[1]);
`else
    assign w_shr = {1'b0, r_mant[MANT_W:1]};
`endif

    always_comb begin
        w_state  = r_state;
        w_mant   = r_mant;
        w_exp    = r_exp;
        w_sign   = r_sign;
        w_result = r_result;
        w_ready  = r_ready;
        w_ovf    = r_ovf;
        w_unf    = r_unf;
        w_zero   = r_zero;
        if (load) begin
            w_state  = S_NORM;
            w_mant   = {c_out, sum};
            w_exp    = exp_in;
            w_sign   = sign_in;
            w_result = '0;
            w_ready  = 1'b0;
            w_ovf    = 1'b0;
            w_unf    = 1'b0;
            w_zero   = 1'b0;
        end else begin
            case (r_state)
                S_NORM: begin
                    if (r_mant == '0) begin
                        w_zero   = 1'b1;
                        w_result = {r_sign, {(EXP_W+MANT_W-1){1'b0}}};
                        w_ready  = 1'b1;
                        w_state  = S_DONE;
                    end else if (r_mant[MANT_W]) begin
                        if (r_exp >= C_EXP_OVF) begin
                            w_ovf    = 1'b1;
                            w_result = {r_sign, C_EXP_INF, {(MANT_W-1){1'b0}}};
                            w_ready  = 1'b1;
                            w_state  = S_DONE;
                        end else begin
                            w_mant = w_shr;
                            w_exp  = r_exp + C_EXP_ONE;
                        end
                    end else if (r_mant[MANT_W-1]) begin
                        w_result = {r_sign, r_exp, r_mant[MANT_W-2:0]};
                        w_ready  = 1'b1;
                        w_state  = S_DONE;
                    end else if (r_exp <= C_EXP_ONE) begin
                        // Exponent floor reached: emit as denormal without further shifts.
                        w_unf    = 1'b1;
                        w_result = {r_sign, {EXP_W{1'b0}}, r_mant[MANT_W-2:0]};
                        w_ready  = 1'b1;
                        w_state  = S_DONE;
                    end else begin
                        w_mant = {r_mant[MANT_W-1:0], 1'b0};
                        w_exp  = r_exp - C_EXP_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mant   <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (en) begin
            r_state  <= w_state;
            r_mant   <= w_mant;
            r_exp    <= w_exp;
            r_sign   <= w_sign;
            r_result <= w_result;
            r_ready  <= w_ready;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
            r_zero   <= w_zero;
        end
    end

    assign result    = r_result;
    assign ready     = r_ready;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_normalizer
// Brief    : Scoreboard bench for fp_add_normalizer (result, flags, latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_normalizer;

    localparam logic [2:0] F_N = 3'b000;
    localparam logic [2:0] F_O = 3'b100;
    localparam logic [2:0] F_U = 3'b010;
    localparam logic [2:0] F_Z = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [23:0] sum = '0;
    logic        c_out = 1'b0;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [31:0] result;
    logic        ready, overflow, underflow, zero;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } exp_t;

    typedef struct {
        logic [23:0] s;
        logic        c;
        logic        sg;
        logic [7:0]  e;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    fp_add_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .sum       (sum),
        .c_out     (c_out),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .result    (result),
        .ready     (ready),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Drives one load and counts cycles until ready; stall_at>=0 drops en for 3 cycles.
    task automatic run_op(input logic [23:0] s, input logic c, input logic sg,
                          input logic [7:0] e, input int stall_at,
                          output logic [31:0] r, output logic [2:0] f,
                          output int lat, output logic rdy0);
        @(negedge clk);
        sum = s; c_out = c; sign_in = sg; exp_in = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rdy0 = ready;
        lat  = 0;
        while (!ready && lat < 200) begin
            if (lat == stall_at) begin
                en = 1'b0;
                repeat (3) @(negedge clk);
                en = 1'b1;
                lat += 3;
            end
            @(negedge clk);
            lat++;
        end
        r = result;
        f = {overflow, underflow, zero};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({result, ready, overflow, underflow, zero} !== 36'd0) begin
            n_mis++;
            $display("FAIL reset_state: got result=%h rdy=%b flags=%b%b%b, want all zero",
                     result, ready, overflow, underflow, zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors(input string name, input vec_t v[]);
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        logic        rdy0;
        exp_t        x;
        foreach (v[i]) begin
            sb.push_back('{res: v[i].res, flg: v[i].flg, lat: v[i].lat});
            run_op(v[i].s, v[i].c, v[i].sg, v[i].e, -1, r, f, lat, rdy0);
            x = sb.pop_front();
            n_cmp++;
            if (rdy0 !== 1'b0) begin
                n_mis++;
                $display("FAIL %s[%0d] ready_after_load: got %b want 0", name, i, rdy0);
            end
            n_cmp++;
            if (r !== x.res) begin
                n_mis++;
                $display("FAIL %s[%0d] result: got %h want %h", name, i, r, x.res);
            end
            n_cmp++;
            if (f !== x.flg) begin
                n_mis++;
                $display("FAIL %s[%0d] flags(o,u,z): got %b want %b", name, i, f, x.flg);
            end
            n_cmp++;
            if (lat !== x.lat) begin
                n_mis++;
                $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, x.lat);
            end
        end
    endtask

    task automatic test_normalize();
        vec_t v[] = '{
            '{24'h800000, 1'b0, 1'b0, 8'h80, 32'h40000000, F_N, 1},
            '{24'h000001, 1'b0, 1'b1, 8'h90, 32'hBC800000, F_N, 24},
            '{24'hFFFFFF, 1'b0, 1'b1, 8'h7F, 32'hBFFFFFFF, F_N, 1},
            '{24'h000100, 1'b0, 1'b0, 8'h03, 32'h00000400, F_U, 3},
            '{24'h400000, 1'b0, 1'b0, 8'h02, 32'h00800000, F_N, 2},
            '{24'h400000, 1'b0, 1'b0, 8'h00, 32'h00400000, F_U, 1}
        };
        test_vectors("normalize", v);
    endtask

    task automatic test_carry();
`ifdef FP_NORM_ROUND_EN
        vec_t v[] = '{
            '{24'h800000, 1'b1, 1'b0, 8'h80, 32'h40C00000, F_N, 2},
            '{24'h800000, 1'b1, 1'b0, 8'hFE, 32'h7F800000, F_O, 1},
            '{24'h800000, 1'b1, 1'b1, 8'hFD, 32'hFF400000, F_N, 2},
            '{24'h800003, 1'b1, 1'b0, 8'h80, 32'h40C00002, F_N, 2},
            '{24'h800001, 1'b1, 1'b0, 8'h80, 32'h40C00000, F_N, 2},
            '{24'hFFFFFF, 1'b1, 1'b0, 8'h80, 32'h41000000, F_N, 3}
        };
`else
        vec_t v[] = '{
            '{24'h800000, 1'b1, 1'b0, 8'h80, 32'h40C00000, F_N, 2},
            '{24'h800000, 1'b1, 1'b0, 8'hFE, 32'h7F800000, F_O, 1},
            '{24'h800000, 1'b1, 1'b1, 8'hFD, 32'hFF400000, F_N, 2},
            '{24'h800003, 1'b1, 1'b0, 8'h80, 32'h40C00001, F_N, 2},
            '{24'h800001, 1'b1, 1'b0, 8'h80, 32'h40C00000, F_N, 2},
            '{24'hFFFFFF, 1'b1, 1'b0, 8'h80, 32'h40FFFFFF, F_N, 2}
        };
`endif
        test_vectors("carry", v);
    endtask

    task automatic test_zero();
        vec_t v[] = '{
            '{24'h000000, 1'b0, 1'b0, 8'h80, 32'h00000000, F_Z, 1},
            '{24'h000000, 1'b0, 1'b1, 8'h00, 32'h80000000, F_Z, 1}
        };
        test_vectors("zero", v);
    endtask

    task automatic test_stall();
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        logic        rdy0;
        exp_t        x;
        sb.push_back('{res: 32'h3C800000, flg: F_N, lat: 27});
        run_op(24'h000001, 1'b0, 1'b0, 8'h90, 5, r, f, lat, rdy0);
        x = sb.pop_front();
        n_cmp++;
        if (r !== x.res) begin
            n_mis++;
            $display("FAIL stall result: got %h want %h", r, x.res);
        end
        n_cmp++;
        if (lat !== x.lat) begin
            n_mis++;
            $display("FAIL stall latency: got %0d want %0d", lat, x.lat);
        end
    endtask

    task automatic test_abort();
        vec_t v[] = '{
            '{24'h800000, 1'b0, 1'b0, 8'h80, 32'h40000000, F_N, 1}
        };
        // Reset at edge N+5 during a long normalization.
        @(negedge clk);
        sum = 24'h000001; c_out = 1'b0; sign_in = 1'b1; exp_in = 8'h90; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({result, ready, overflow, underflow, zero} !== 36'd0) begin
            n_mis++;
            $display("FAIL abort_reset: got result=%h rdy=%b flags=%b%b%b, want all zero",
                     result, ready, overflow, underflow, zero);
        end
        rst_n = 1'b1;
        // Reload mid-normalization; the new operand must win.
        @(negedge clk);
        sum = 24'h000001; exp_in = 8'h90; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_load_pending: got ready=%b want 0", ready);
        end
        test_vectors("abort_load", v);
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_carry();
        test_zero();
        test_stall();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
